// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (I-cache / D-cache) line-burst arbiter for a single
//            multi-cycle main-memory port. Optional macro MEM_ARB_RR_EN selects
//            round-robin arbitration; the default is fixed D-over-I priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int BW        = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic              ic_we_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic [DATA_W-1:0] ic_wdata_i,
  output logic              ic_gnt_o,
  output logic [BW-1:0]     ic_beat_o,
  output logic              ic_rvalid_o,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_gnt_o,
  output logic [BW-1:0]     dc_beat_o,
  output logic              dc_rvalid_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int          OFF       = BW + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = D-cache owns the port
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              pick_dc;
  logic [ADDR_W-1:0] sel_addr;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  // On a tie, the requester that did not own the previous burst wins.
  always_comb begin
    pick_dc      = dc_req_i && (!ic_req_i || !last_owner_q);
    last_owner_d = last_owner_q;
    if (state_q == S_IDLE && (ic_req_i || dc_req_i)) begin
      last_owner_d = pick_dc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_owner_q <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  always_comb begin
    pick_dc = dc_req_i;
  end
`endif

  assign sel_addr = pick_dc ? dc_addr_i : ic_addr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    base_d  = base_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          owner_d = pick_dc;
          we_d    = pick_dc ? dc_we_i : ic_we_i;
          base_d  = {sel_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          beat_d  = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (mem_ack_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic in_burst;
  logic granted;
  logic rd_beat;

  // Outputs decode registered state only, so an async reset clears them at once.
  always_comb begin
    in_burst    = (state_q == S_BURST);
    granted     = (state_q == S_BURST) || (state_q == S_DONE);
    rd_beat     = in_burst && mem_ack_i && !we_q;

    mem_req_o   = in_burst;
    mem_we_o    = in_burst && we_q;
    mem_addr_o  = in_burst ? (base_q | {{(ADDR_W-OFF){1'b0}}, beat_q, 2'b00}) : '0;
    mem_wdata_o = in_burst ? (owner_q ? dc_wdata_i : ic_wdata_i) : '0;

    ic_gnt_o    = granted && !owner_q;
    ic_beat_o   = ic_gnt_o ? beat_q : '0;
    ic_rvalid_o = rd_beat && !owner_q;
    ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : '0;
    ic_done_o   = (state_q == S_DONE) && !owner_q;

    dc_gnt_o    = granted && owner_q;
    dc_beat_o   = dc_gnt_o ? beat_q : '0;
    dc_rvalid_o = rd_beat && owner_q;
    dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : '0;
    dc_done_o   = (state_q == S_DONE) && owner_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter (LINE_WORDS=4); expected memory
//            beats and done pulses are queued when requests are driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [31:0] RKEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ic_req_i = 1'b0, ic_we_i = 1'b0;
  logic [31:0] ic_addr_i = '0, ic_wdata_i;
  logic        ic_gnt_o, ic_rvalid_o, ic_done_o;
  logic [1:0]  ic_beat_o;
  logic [31:0] ic_rdata_o;
  logic        dc_req_i = 1'b0, dc_we_i = 1'b0;
  logic [31:0] dc_addr_i = '0, dc_wdata_i;
  logic        dc_gnt_o, dc_rvalid_o, dc_done_o;
  logic [1:0]  dc_beat_o;
  logic [31:0] dc_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_en = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        dc;
    logic [1:0]  beat;
  } beat_t;

  beat_t exp_q[$];
  bit    done_q[$];

  mem_arbiter #(.LINE_WORDS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ic_req_i(ic_req_i), .ic_we_i(ic_we_i), .ic_addr_i(ic_addr_i), .ic_wdata_i(ic_wdata_i),
    .ic_gnt_o(ic_gnt_o), .ic_beat_o(ic_beat_o), .ic_rvalid_o(ic_rvalid_o),
    .ic_rdata_o(ic_rdata_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_gnt_o(dc_gnt_o), .dc_beat_o(dc_beat_o), .dc_rvalid_o(dc_rvalid_o),
    .dc_rdata_o(dc_rdata_o), .dc_done_o(dc_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Zero-wait memory, with an optional stall on I-cache beat 1.
  assign mem_ack_i   = mem_req_o && !(stall_en && ic_beat_o == 2'd1);
  assign mem_rdata_i = mem_addr_o ^ RKEY;
  assign ic_wdata_i  = 32'h1C0 + 32'(ic_beat_o);
  assign dc_wdata_i  = 32'hA0 + 32'(dc_beat_o);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_burst(input bit dc, input bit we, input logic [31:0] addr);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.addr  = {addr[31:4], 4'h0} + 32'(i * 4);
      b.we    = we;
      b.wdata = dc ? 32'hA0 + 32'(i) : 32'h1C0 + 32'(i);
      b.dc    = dc;
      b.beat  = 2'(i);
      exp_q.push_back(b);
    end
    done_q.push_back(dc);
  endtask

  task automatic wait_done(input bit dc, output int done_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dc ? dc_done_o : ic_done_o) && n < 60);
    check(dc ? "dc_done_seen" : "ic_done_seen", dc ? dc_done_o : ic_done_o, 1);
    done_cyc = cyc;
  endtask

  beat_t e;
  bit    d;
  always @(negedge clk) begin
    if (rst_ni) begin
      if (mem_req_o && mem_ack_i) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mem_addr", mem_addr_o, e.addr);
          check("mem_we", mem_we_o, e.we);
          if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
          check("owner_gnt", e.dc ? dc_gnt_o : ic_gnt_o, 1);
          check("other_gnt", e.dc ? ic_gnt_o : dc_gnt_o, 0);
          check("owner_beat", e.dc ? dc_beat_o : ic_beat_o, e.beat);
          check("owner_rvalid", e.dc ? dc_rvalid_o : ic_rvalid_o, !e.we);
          check("other_rvalid", e.dc ? ic_rvalid_o : dc_rvalid_o, 0);
          check("owner_rdata", e.dc ? dc_rdata_o : ic_rdata_o, e.we ? 32'h0 : (e.addr ^ RKEY));
        end
      end else if (mem_req_o && exp_q.size() > 0) begin
        check("stall_addr", mem_addr_o, exp_q[0].addr);
        check("stall_beat", exp_q[0].dc ? dc_beat_o : ic_beat_o, exp_q[0].beat);
        check("stall_rvalid", {ic_rvalid_o, dc_rvalid_o}, 2'b00);
      end
      if (ic_done_o || dc_done_o) begin
        check("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          check("done_owner", {ic_done_o, dc_done_o}, d ? 2'b01 : 2'b10);
          check("done_gnt", {ic_gnt_o, dc_gnt_o}, d ? 2'b01 : 2'b10);
          check("done_no_memreq", mem_req_o, 0);
        end
      end
    end
  end

  int k, dcyc, n;

  initial begin
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_outputs", {mem_req_o, ic_gnt_o, dc_gnt_o, ic_done_o, dc_done_o, ic_beat_o, dc_beat_o}, 0);
    check("rst_addr", mem_addr_o, 0);

    // I-cache line refill, unaligned address within the line.
    ic_addr_i = 32'h0000_104C; ic_we_i = 1'b0; ic_req_i = 1'b1;
    push_burst(1'b0, 1'b0, 32'h104C);
    k = cyc;
    wait_done(1'b0, dcyc);
    ic_req_i = 1'b0;
    check("ic_latency", dcyc - k + 1, 6);

    // D-cache write-back.
    @(negedge clk);
    dc_addr_i = 32'h2000; dc_we_i = 1'b1; dc_req_i = 1'b1;
    push_burst(1'b1, 1'b1, 32'h2000);
    k = cyc;
    wait_done(1'b1, dcyc);
    dc_req_i = 1'b0;
    check("dc_latency", dcyc - k + 1, 6);

    // Simultaneous requests.
    @(negedge clk);
    ic_addr_i = 32'h0000_6010; ic_we_i = 1'b0;
    dc_addr_i = 32'h0000_7020; dc_we_i = 1'b0;
    ic_req_i = 1'b1; dc_req_i = 1'b1;
`ifdef MEM_ARB_RR_EN
    push_burst(1'b0, 1'b0, 32'h6010);
    push_burst(1'b1, 1'b0, 32'h7020);
    wait_done(1'b0, dcyc); ic_req_i = 1'b0;
    wait_done(1'b1, dcyc); dc_req_i = 1'b0;
`else
    push_burst(1'b1, 1'b0, 32'h7020);
    push_burst(1'b0, 1'b0, 32'h6010);
    wait_done(1'b1, dcyc); dc_req_i = 1'b0;
    wait_done(1'b0, dcyc); ic_req_i = 1'b0;
`endif

    // Memory stalls three cycles on beat 1.
    @(negedge clk);
    stall_en = 1'b1;
    ic_addr_i = 32'h0000_3008; ic_req_i = 1'b1;
    push_burst(1'b0, 1'b0, 32'h3008);
    k = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!(ic_gnt_o && ic_beat_o == 2'd1) && n < 20);
    check("stall_reached", ic_beat_o, 1);
    repeat (2) @(negedge clk);
    check("stall_hold_beat", ic_beat_o, 1);
    check("stall_hold_req", mem_req_o, 1);
    @(posedge clk);
    #1 stall_en = 1'b0;
    wait_done(1'b0, dcyc);
    ic_req_i = 1'b0;
    check("stall_latency", dcyc - k + 1, 9);

    // Asynchronous reset in the middle of beat 2.
    @(negedge clk);
    dc_addr_i = 32'h0000_4000; dc_we_i = 1'b0; dc_req_i = 1'b1;
    push_burst(1'b1, 1'b0, 32'h4000);
    n = 0;
    do begin @(negedge clk); n++; end while (!(dc_gnt_o && dc_beat_o == 2'd2) && n < 20);
    check("rst_mid_reached", dc_beat_o, 2);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_memreq", mem_req_o, 0);
    check("rst_mid_gnt", dc_gnt_o, 0);
    check("rst_mid_beat", dc_beat_o, 0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    push_burst(1'b1, 1'b0, 32'h4000);
    k = cyc;
    wait_done(1'b1, dcyc);
    dc_req_i = 1'b0;
    check("rst_restart_latency", dcyc - k + 1, 6);

    // Request held through DONE: re-grant only from the following IDLE.
    @(negedge clk);
    dc_addr_i = 32'h0000_5000; dc_we_i = 1'b0; dc_req_i = 1'b1;
    push_burst(1'b1, 1'b0, 32'h5000);
    push_burst(1'b1, 1'b0, 32'h5000);
    wait_done(1'b1, dcyc);
    @(negedge clk);
    check("held_idle_gnt", dc_gnt_o, 0);
    check("held_idle_memreq", mem_req_o, 0);
    @(negedge clk);
    check("held_regrant", dc_gnt_o, 1);
    wait_done(1'b1, dcyc);
    dc_req_i = 1'b0;

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
